sign_apply_serial: RTL and testbench
====================================

// Module: sign_apply_serial
// PURPOSE
// - Inverse of the absolute-value unit: takes an unsigned magnitude plus a sign bit and
//   returns the two's-complement value Z = sign ? -MAG : MAG.
// - Digit-serial: one DIGIT-bit slice per cycle, carry held in a register.
// - Sits behind magnitude datapaths (sign-magnitude multipliers/dividers) to restore signed results.
// - Valid/ready on input and output.
// PARAMETERS
// - width  16  operand/result word width (>= 2)
// - digit   4  bits processed per cycle; must divide width, else $error at elaboration
// - speed   1  carry-lookahead style inside a digit: 0 serial, 1 Brent-Kung, 2 Sklansky
// PORTS
// - clk_i        in   1      clock, rising edge
// - rst_ni       in   1      asynchronous reset, active low
// - in_valid_i   in   1      mag_i/sign_i valid
// - in_ready_o   out  1      block can accept (state IDLE)
// - mag_i        in   width  unsigned magnitude
// - sign_i       in   1      1 = negate
// - out_valid_o  out  1      z_o/ovf_o valid (state DONE)
// - out_ready_i  in   1      consumer accepts result
// - z_o          out  width  two's-complement result
// - ovf_o        out  1      magnitude not representable with the requested sign
// BEHAVIOUR
// - Reset (rst_ni=0, async): state IDLE, z_o=0, ovf_o=0, out_valid_o=0, in_ready_o=1, carry=0.
// - ND = width/digit. States: IDLE -> BUSY on in_valid_i & in_ready_o.
//   BUSY lasts ND cycles; digit counter runs 0..ND-1.
//   BUSY -> DONE after digit ND-1. DONE -> IDLE on out_ready_i.
// - in_ready_o = (state==IDLE), combinational from the state register.
// - out_valid_o = (state==DONE). z_o and ovf_o stay stable while out_valid_o & !out_ready_i.
// - Accept: capture mag_i and sign_i; set carry = sign_i; clear the nz_low flag.
// - BUSY digit j: d = mag[j*digit +: digit] ^ {digit{sign}}; {c', r} = d + carry;
//   z[j*digit +: digit] = r; carry <= c'.
//   nz_low accumulates OR of mag bits [width-2:0] seen so far.
// - Latency: out_valid_o rises ND cycles after the accepting edge.
//   No new input is accepted until DONE->IDLE, i.e. at most one transaction in flight.
//   Minimum accept-to-accept period is ND+2 cycles (one IDLE cycle between transactions).
// - Overflow, evaluated at the last digit:
//   - sign=0: ovf = mag[width-1].
//   - sign=1: ovf = mag[width-1] & nz_low.
//   - mag = 2^(width-1) with sign=1 is legal and gives 100..0.
// - Zero: mag=0 with sign=1 gives z=0, ovf=0 (no negative zero).
//   The final carry out of the MSB digit is discarded.
// - Reset asserted mid-BUSY or in DONE aborts immediately. The partial result is lost
//   and outputs return to reset values.
// - out_ready_i is ignored outside DONE. in_valid_i is ignored outside IDLE.
// CONFIGURATION
// - Macro SIGN_APPLY_SAT_EN.
// - Defined: on ovf=1, z_o saturates.
//   - sign=0: 0111..1.
//   - sign=1: 1000..0.
//   - ovf_o is still reported.
// - Undefined: z_o is the wrapped (modulo 2^width) result; ovf_o is reported. No saturation logic.
// STRUCTURE
// - Package sign_apply_pkg:
//   - typedef enum logic [1:0] {IDLE, BUSY, DONE} sa_state_e.
//   - function sa_num_digits(width, digit) returning width/digit.
// - Sub-module digit_cond_neg (digit, speed): combinational d ^ sign plus carry-in.
//   - Carry chain style selected by speed.
//   - Outputs r[digit-1:0] and carry out.
//   - The sequencing FSM, counter, carry/flag registers and result register stay in sign_apply_serial.
// TESTING
// All cases use width=16, digit=4 (ND=4).
// - mag=0x0005, sign=1, accepted at edge N -> out_valid_o at edge N+4; z=0xFFFB, ovf=0.
// - mag=0x8000, sign=1 -> z=0x8000, ovf=0. mag=0x0000, sign=1 -> z=0x0000, ovf=0.
// - mag=0x8001, sign=1 -> ovf=1; z=0x7FFF (wrap), or z=0x8000 with SIGN_APPLY_SAT_EN.
//   mag=0x9000, sign=0 -> ovf=1; z=0x9000 (wrap), or z=0x7FFF with SIGN_APPLY_SAT_EN.
// - out_ready_i held low 3 cycles in DONE -> z_o/ovf_o stable, in_ready_o=0.
//   New in_valid_i during BUSY is not accepted.
//   Back-to-back: next accept occurs exactly one cycle after the DONE handshake.
// - rst_ni pulsed low during BUSY digit 2 -> out_valid_o=0, z_o=0, in_ready_o=1 immediately.
//   After release, mag=0x1234, sign=1 -> z=0xEDCC.
// - Random 10k vectors, all three speed values: z_o equals the sign ? -mag : mag reference model,
//   with ovf_o per the rules above.

Source files
------------

// File: rtl/sign_apply_pkg.sv
// Shared types and helpers for the digit-serial sign-apply unit.
package sign_apply_pkg;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} sa_state_e;

   function automatic int sa_num_digits(input int width, input int digit);
      return width / digit;
   endfunction

endpackage

// File: rtl/sign_apply_serial_digit_cond_neg.sv
// One digit of conditional negation: r = (mag ^ {sign}) + cin, with the carry
// chain shape chosen by speed (0 ripple, 1 Brent-Kung, 2 Sklansky).
module digit_cond_neg #(
   parameter int digit = 4,
   parameter int speed = 1
) (
   input  logic [digit-1:0] mag,
   input  logic             sign,
   input  logic             cin,
   output logic [digit-1:0] r,
   output logic             cout
);

   localparam int LV = $clog2(digit);

   logic [digit-1:0] d;
   logic [digit-1:0] p;
   logic [digit-1:0] c;

   assign d = mag ^ {digit{sign}};

   // Adding a lone carry-in only needs the AND-prefix of d: carry into bit i
   // is cin & d[i-1:0] all ones.
   always_comb begin
      p = d;
      if (speed == 0) begin
         for (int i = 1; i < digit; i++) p[i] = p[i] & p[i-1];
      end else if (speed == 2) begin
         for (int l = 0; l < LV; l++)
            for (int i = 0; i < digit; i++)
               if (((i >> l) & 1) == 1) p[i] = p[i] & p[((i >> l) << l) - 1];
      end else begin
         for (int l = 0; l < LV; l++)
            for (int i = 0; i < digit; i++)
               if (((i + 1) % (1 << (l + 1))) == 0) p[i] = p[i] & p[i - (1 << l)];
         for (int l = LV - 1; l >= 0; l--)
            for (int i = 0; i < digit; i++)
               if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && (i >= (1 << (l + 1))))
                  p[i] = p[i] & p[i - (1 << l)];
      end
   end

   always_comb begin
      c = '0;
      c[0] = cin;
      for (int i = 1; i < digit; i++) c[i] = cin & p[i-1];
   end

   assign r    = d ^ c;
   assign cout = cin & p[digit-1];

endmodule

// File: rtl/sign_apply_serial.sv
// Digit-serial Z = sign ? -MAG : MAG with overflow flag and valid/ready handshakes.
// Define SIGN_APPLY_SAT_EN to saturate z_o on overflow instead of wrapping.
module sign_apply_serial
   import sign_apply_pkg::*;
#(
   parameter int width = 16,
   parameter int digit = 4,
   parameter int speed = 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [width-1:0] mag_i,
   input  logic             sign_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [width-1:0] z_o,
   output logic             ovf_o
);

   localparam int ND = sa_num_digits(width, digit);
   localparam int CW = (ND > 1) ? $clog2(ND) : 1;
   localparam logic [digit-1:0] LOW_MASK = {digit{1'b1}} >> 1;
   localparam logic [width-1:0] Z_MIN = {1'b1, {(width-1){1'b0}}};
   localparam logic [width-1:0] Z_MAX = {1'b0, {(width-1){1'b1}}};

   if (((width % digit) != 0) || (width < 2)) begin : g_param_chk
      $error("sign_apply_serial: digit must divide width and width must be >= 2");
   end

   sa_state_e state, state_nx;

   logic [CW-1:0]          cnt;
   logic                   carry;
   logic                   nz_low;
   logic                   sign_q;
   logic [width-1:0]       mag_sh;
   logic [width-1:0]       z_q;
   logic                   ovf_q;
   logic                   last;
   logic                   accept;
   logic [digit-1:0]       dig_r;
   logic                   dig_c;
   logic                   nz_dig;
   logic                   ovf_nx;
   logic [width+digit-1:0] z_cat;
   logic [width-1:0]       z_nx;
   logic [width-1:0]       z_fin;

   assign last   = (cnt == CW'(ND - 1));
   assign accept = in_valid_i & in_ready_o;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state <= IDLE;
      else         state <= state_nx;
   end

   always_comb begin
      state_nx    = state;
      in_ready_o  = 1'b0;
      out_valid_o = 1'b0;
      case (state)
         IDLE: begin
            in_ready_o = 1'b1;
            if (in_valid_i) state_nx = BUSY;
         end
         BUSY:    if (last) state_nx = DONE;
         DONE: begin
            out_valid_o = 1'b1;
            if (out_ready_i) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // The magnitude is consumed from the bottom; the result fills in from the top.
   digit_cond_neg #(.digit(digit), .speed(speed)) u_digit (
      .mag  (mag_sh[digit-1:0]),
      .sign (sign_q),
      .cin  (carry),
      .r    (dig_r),
      .cout (dig_c)
   );

   always_comb begin
      // On the last digit the top magnitude bit is the overflow candidate, not part of nz_low.
      nz_dig = last ? |(mag_sh[digit-1:0] & LOW_MASK) : |mag_sh[digit-1:0];
      ovf_nx = mag_sh[digit-1] & (~sign_q | nz_low | nz_dig);
      z_cat  = {dig_r, z_q};
      z_nx   = z_cat[width+digit-1:digit];
`ifdef SIGN_APPLY_SAT_EN
      z_fin  = ovf_nx ? (sign_q ? Z_MIN : Z_MAX) : z_nx;
`else
      z_fin  = z_nx;
`endif
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt    <= '0;
         carry  <= 1'b0;
         nz_low <= 1'b0;
         sign_q <= 1'b0;
         mag_sh <= '0;
         z_q    <= '0;
         ovf_q  <= 1'b0;
      end else if (accept) begin
         cnt    <= '0;
         carry  <= sign_i;
         nz_low <= 1'b0;
         sign_q <= sign_i;
         mag_sh <= mag_i;
         ovf_q  <= 1'b0;
      end else if (state == BUSY) begin
         carry  <= dig_c;
         nz_low <= nz_low | nz_dig;
         mag_sh <= mag_sh >> digit;
         if (last) begin
            cnt   <= '0;
            z_q   <= z_fin;
            ovf_q <= ovf_nx;
         end else begin
            cnt   <= cnt + 1'b1;
            z_q   <= z_nx;
         end
      end
   end

   assign z_o   = z_q;
   assign ovf_o = ovf_q;

endmodule

// File: tb/tb_sign_apply_serial.sv
// Randomized and directed checks of sign_apply_serial against an arithmetic
// reference model, with one instance per carry-chain speed setting.
module tb_sign_apply_serial;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        sign_i = 1'b0;
   logic        out_ready_i = 1'b0;
   logic [15:0] mag_i = '0;

   logic [2:0]  in_ready;
   logic [2:0]  out_valid;
   logic [2:0]  ovf;
   logic [15:0] z [3];

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk_i = ~clk_i;

   sign_apply_serial #(.width(16), .digit(4), .speed(0)) u_dut0 (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready[0]),
      .mag_i(mag_i), .sign_i(sign_i), .out_valid_o(out_valid[0]), .out_ready_i(out_ready_i),
      .z_o(z[0]), .ovf_o(ovf[0]));
   sign_apply_serial #(.width(16), .digit(4), .speed(1)) u_dut1 (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready[1]),
      .mag_i(mag_i), .sign_i(sign_i), .out_valid_o(out_valid[1]), .out_ready_i(out_ready_i),
      .z_o(z[1]), .ovf_o(ovf[1]));
   sign_apply_serial #(.width(16), .digit(4), .speed(2)) u_dut2 (
      .clk_i(clk_i), .rst_ni(rst_ni), .in_valid_i(in_valid_i), .in_ready_o(in_ready[2]),
      .mag_i(mag_i), .sign_i(sign_i), .out_valid_o(out_valid[2]), .out_ready_i(out_ready_i),
      .z_o(z[2]), .ovf_o(ovf[2]));

   // Reference: plain integer negation, range test for overflow.
   function automatic logic [16:0] ref_model(input logic [15:0] m, input logic s);
      int          mag;
      logic [31:0] v;
      logic        o;
      logic [15:0] r;
      mag = int'(m);
      v   = s ? 32'(-mag) : 32'(mag);
      o   = s ? (mag > 32768) : (mag >= 32768);
      r   = v[15:0];
`ifdef SIGN_APPLY_SAT_EN
      if (o) r = s ? 16'h8000 : 16'h7FFF;
`endif
      return {o, r};
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic run_txn(input logic [15:0] m, input logic s, output int lat, output logic ok);
      int g;
      g   = 0;
      ok  = 1'b1;
      lat = 0;
      while (!in_ready[1] && g < 20) begin step(); g++; end
      if (!in_ready[1]) begin ok = 1'b0; return; end
      in_valid_i = 1'b1; mag_i = m; sign_i = s;
      step();
      in_valid_i = 1'b0;
      while (!out_valid[1] && lat < 20) begin step(); lat++; end
      if (!out_valid[1]) ok = 1'b0;
   endtask

   task automatic finish_hs();
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_ni = 1'b0;
      repeat (3) step();
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (z[k] !== 16'h0 || ovf[k] !== 1'b0 || out_valid[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            $display("FAIL reset dut%0d: z=%h ovf=%b ov=%b ir=%b, want z=0000 ovf=0 ov=0 ir=1",
                     k, z[k], ovf[k], out_valid[k], in_ready[k]);
            n_bad++;
         end
      end
      #3 rst_ni = 1'b1;
      step();
   endtask

   task automatic test_directed();
      logic [15:0] mags [8] = '{16'h0005, 16'h8000, 16'h0000, 16'h8001,
                                16'h9000, 16'h7FFF, 16'hFFFF, 16'h1234};
      logic        sgns [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      int          lat;
      logic        ok;
      logic [16:0] e;
      for (int t = 0; t < 8; t++) begin
         run_txn(mags[t], sgns[t], lat, ok);
         e = ref_model(mags[t], sgns[t]);
         n_vec++;
         if (!ok || lat != 4) begin
            $display("FAIL latency mag=%h: got %0d cycles (ok=%b), want 4", mags[t], lat, ok);
            n_bad++;
         end
         for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (z[k] !== e[15:0] || ovf[k] !== e[16]) begin
               $display("FAIL directed dut%0d mag=%h sign=%b: z=%h ovf=%b, want z=%h ovf=%b",
                        k, mags[t], sgns[t], z[k], ovf[k], e[15:0], e[16]);
               n_bad++;
            end
         end
         finish_hs();
      end
   endtask

   task automatic test_stall();
      logic [16:0] e;
      e = ref_model(16'h00A5, 1'b0);
      in_valid_i = 1'b1; mag_i = 16'h00A5; sign_i = 1'b0;
      step();
      // A competing request held through BUSY must be ignored.
      mag_i = 16'h4444; sign_i = 1'b1;
      for (int c = 0; c < 4; c++) begin
         n_vec++;
         if (in_ready[1] !== 1'b0) begin
            $display("FAIL busy_ready cycle %0d: in_ready=%b, want 0", c, in_ready[1]);
            n_bad++;
         end
         step();
      end
      in_valid_i = 1'b0;
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (out_valid[k] !== 1'b1 || in_ready[k] !== 1'b0 || z[k] !== e[15:0] || ovf[k] !== e[16]) begin
               $display("FAIL stall dut%0d cycle %0d: ov=%b ir=%b z=%h ovf=%b, want ov=1 ir=0 z=%h ovf=%b",
                        k, c, out_valid[k], in_ready[k], z[k], ovf[k], e[15:0], e[16]);
               n_bad++;
            end
         end
         if (c < 3) step();
      end
      finish_hs();
   endtask

   task automatic test_back_to_back();
      int          lat;
      logic        ok;
      logic [16:0] e;
      run_txn(16'h0F0F, 1'b1, lat, ok);
      n_vec++;
      if (!ok) begin $display("FAIL b2b_first: timed out, want result"); n_bad++; end
      out_ready_i = 1'b1; in_valid_i = 1'b1; mag_i = 16'h00FF; sign_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      n_vec++;
      if (in_ready[1] !== 1'b1 || out_valid[1] !== 1'b0) begin
         $display("FAIL b2b_idle: ir=%b ov=%b, want ir=1 ov=0", in_ready[1], out_valid[1]);
         n_bad++;
      end
      step();
      in_valid_i = 1'b0;
      n_vec++;
      if (in_ready[1] !== 1'b0) begin
         $display("FAIL b2b_accept: ir=%b, want 0", in_ready[1]);
         n_bad++;
      end
      repeat (3) step();
      n_vec++;
      if (out_valid[1] !== 1'b0) begin
         $display("FAIL b2b_early: ov=%b, want 0", out_valid[1]);
         n_bad++;
      end
      step();
      e = ref_model(16'h00FF, 1'b1);
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (out_valid[k] !== 1'b1 || z[k] !== e[15:0] || ovf[k] !== e[16]) begin
            $display("FAIL b2b_result dut%0d: ov=%b z=%h ovf=%b, want ov=1 z=%h ovf=%b",
                     k, out_valid[k], z[k], ovf[k], e[15:0], e[16]);
            n_bad++;
         end
      end
      finish_hs();
   endtask

   task automatic test_reset_mid();
      int   lat;
      logic ok;
      in_valid_i = 1'b1; mag_i = 16'hBEEF; sign_i = 1'b1;
      step();
      in_valid_i = 1'b0;
      repeat (2) step();
      #1 rst_ni = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (out_valid[k] !== 1'b0 || z[k] !== 16'h0 || ovf[k] !== 1'b0 || in_ready[k] !== 1'b1) begin
            $display("FAIL reset_mid dut%0d: ov=%b z=%h ovf=%b ir=%b, want ov=0 z=0000 ovf=0 ir=1",
                     k, out_valid[k], z[k], ovf[k], in_ready[k]);
            n_bad++;
         end
      end
      #2 rst_ni = 1'b1;
      step();
      run_txn(16'h1234, 1'b1, lat, ok);
      for (int k = 0; k < 3; k++) begin
         n_vec++;
         if (!ok || z[k] !== 16'hEDCC || ovf[k] !== 1'b0) begin
            $display("FAIL post_reset dut%0d: z=%h ovf=%b ok=%b, want z=edcc ovf=0", k, z[k], ovf[k], ok);
            n_bad++;
         end
      end
      finish_hs();
   endtask

   task automatic test_random();
      int          lat;
      logic        ok;
      logic [15:0] m;
      logic        s;
      logic [16:0] e;
      for (int n = 0; n < 10000; n++) begin
         case ($urandom_range(0, 7))
            0:       m = 16'h0000;
            1:       m = 16'h8000;
            2:       m = 16'h8000 | 16'($urandom_range(0, 3));
            3:       m = 16'h7FF0 | 16'($urandom_range(0, 15));
            default: m = 16'($urandom);
         endcase
         s = 1'($urandom);
         e = ref_model(m, s);
         run_txn(m, s, lat, ok);
         n_vec++;
         if (!ok || lat != 4) begin
            $display("FAIL rand_latency mag=%h: got %0d (ok=%b), want 4", m, lat, ok);
            n_bad++;
         end
         for (int k = 0; k < 3; k++) begin
            n_vec++;
            if (z[k] !== e[15:0] || ovf[k] !== e[16]) begin
               $display("FAIL rand dut%0d mag=%h sign=%b: z=%h ovf=%b, want z=%h ovf=%b",
                        k, m, s, z[k], ovf[k], e[15:0], e[16]);
               n_bad++;
            end
         end
         if ($urandom_range(0, 15) == 0) step();
         finish_hs();
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_stall();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
